// File: rtl/morra_pkg.sv
// rtl/morra_pkg.sv - shared result encoding and scoreboard state type
package morra_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } sb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/morra_scoreboard.sv
// rtl/morra_scoreboard.sv - per-match and cumulative tallies for the morra match engine
module morra_scoreboard #(
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 5,
    parameter int MATCH_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    manche,
    input  logic [1:0]                    partita,
    input  logic                          new_match,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [CNT_W-1:0]              p1_rounds,
    output logic [CNT_W-1:0]              p2_rounds,
    output logic [CNT_W-1:0]              draws,
    output logic [CNT_W-1:0]              rounds_total,
    output logic [$clog2(HIST_DEPTH):0]   hist_len,
    output logic [1:0]                    hist_out,
    output logic [1:0]                    winner,
    output logic                          match_done,
    output logic                          busy,
    output logic [MATCH_W-1:0]            p1_matches,
    output logic [MATCH_W-1:0]            p2_matches,
    output logic [MATCH_W-1:0]            draw_matches
);
    import morra_pkg::*;

    localparam int LW = $clog2(HIST_DEPTH) + 1;

    sb_state_t  state;
    logic [1:0] prev_partita;
    logic [1:0] hist [HIST_DEPTH];

    logic partita_edge;
    logic active;
    logic round_evt;
    logic match_evt;

    // new_match wins over any same-cycle round or match event
    assign partita_edge = (prev_partita == RES_NONE) && (partita != RES_NONE);
    assign active       = (state != DONE) && !new_match;
    assign round_evt    = active && (manche != RES_NONE);
    assign match_evt    = active && partita_edge;

    // Edge detector history survives new_match so a held partita never re-fires
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_partita <= RES_NONE;
        end else begin
            prev_partita <= partita;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            winner     <= RES_NONE;
            match_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            match_done <= 1'b0;
            if (new_match) begin
                state  <= IDLE;
                winner <= RES_NONE;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE, PLAY: begin
                        if (match_evt) begin
                            state      <= DONE;
                            winner     <= partita;
                            match_done <= 1'b1;
                            busy       <= 1'b0;
                        end else if (round_evt || (state == PLAY)) begin
                            state <= PLAY;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || new_match) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= RES_NONE;
            end
            hist_len <= '0;
        end else if (round_evt) begin
            hist[0] <= manche;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            if (hist_len != LW'(HIST_DEPTH)) begin
                hist_len <= hist_len + 1'b1;
            end
        end
    end

    always_comb begin
        hist_out = RES_NONE;
        if ({1'b0, hist_idx} < hist_len) begin
            hist_out = hist[hist_idx];
        end
    end

    sat_counter #(.W(CNT_W)) u_p1_rounds (
        .clk(clk), .reset(reset), .clr(new_match),
        .inc(round_evt && (manche == RES_P1)), .q(p1_rounds)
    );

    sat_counter #(.W(CNT_W)) u_p2_rounds (
        .clk(clk), .reset(reset), .clr(new_match),
        .inc(round_evt && (manche == RES_P2)), .q(p2_rounds)
    );

    sat_counter #(.W(CNT_W)) u_draws (
        .clk(clk), .reset(reset), .clr(new_match),
        .inc(round_evt && (manche == RES_DRAW)), .q(draws)
    );

    sat_counter #(.W(CNT_W)) u_rounds_total (
        .clk(clk), .reset(reset), .clr(new_match),
        .inc(round_evt), .q(rounds_total)
    );

    sat_counter #(.W(MATCH_W)) u_p1_matches (
        .clk(clk), .reset(reset), .clr(1'b0),
        .inc(match_evt && (partita == RES_P1)), .q(p1_matches)
    );

    sat_counter #(.W(MATCH_W)) u_p2_matches (
        .clk(clk), .reset(reset), .clr(1'b0),
        .inc(match_evt && (partita == RES_P2)), .q(p2_matches)
    );

    sat_counter #(.W(MATCH_W)) u_draw_matches (
        .clk(clk), .reset(reset), .clr(1'b0),
        .inc(match_evt && (partita == RES_DRAW)), .q(draw_matches)
    );

endmodule

// File: doc/morra_scoreboard.md
# morra_scoreboard

Downstream consumer of the rock-paper-scissors match engine. Samples the engine's per-round result (`manche`) and match result (`partita`) every clock, keeps per-match round tallies, a short round history, and cumulative match tallies across consecutive matches. Produces a one-cycle `match_done` pulse and latched winner for the display/host side.

## Interface
Parameters:
- `HIST_DEPTH`, 8: rounds retained in history (power of two, ≥2).
- `CNT_W`, 5: width of per-match round counters (covers the 19-round maximum).
- `MATCH_W`, 8: width of cumulative match counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; clears everything.
- `manche` in 2: round result; 00 no valid round, 01 P1 wins, 10 P2 wins, 11 draw.
- `partita` in 2: match result; 00 ongoing, 01 P1, 10 P2, 11 draw; held non-zero by the engine until the engine is reset.
- `new_match` in 1: clears per-match state and keeps cumulative tallies.
- `hist_idx` in $clog2(HIST_DEPTH): history read index; 0 is the newest round.
- `p1_rounds`, `p2_rounds`, `draws` out CNT_W each: per-match round tallies.
- `rounds_total` out CNT_W: valid rounds this match.
- `hist_len` out $clog2(HIST_DEPTH)+1: valid history entries.
- `hist_out` out 2: history entry at `hist_idx`.
- `winner` out 2: latched match result, same encoding as `partita`.
- `match_done` out 1: one-cycle pulse when a match ends.
- `busy` out 1: high in PLAY.
- `p1_matches`, `p2_matches`, `draw_matches` out MATCH_W each: cumulative tallies.

## Operation
- FSM states: IDLE, PLAY, DONE. Reset → IDLE.
  - IDLE → PLAY on any non-zero `manche`.
  - IDLE or PLAY → DONE on a `partita` edge, meaning the registered previous `partita` is 00 and the current `partita` is non-zero.
  - DONE → IDLE only on `new_match`. `new_match` in IDLE or PLAY also returns to IDLE and clears per-match state.
- Round accounting happens in IDLE/PLAY for non-zero `manche`:
  - Increment the matching tally and `rounds_total`.
  - Shift `manche` into the history at index 0.
  - Increment `hist_len`, saturating at HIST_DEPTH.
- In DONE, `manche` is ignored.
- On the `partita` edge:
  - `winner` ← `partita`.
  - `match_done` pulses.
  - The matching cumulative counter increments.
  - A non-zero `manche` in the same cycle is counted first, then DONE is entered.
- A `partita` that stays non-zero never re-triggers. The edge detector's previous-value register is updated every cycle, including in DONE. It is cleared by `reset` only, not by `new_match`.
- `new_match` clears tallies, `rounds_total`, history, `hist_len` and `winner`. It has priority over any `manche` or `partita` event in the same cycle; that event is discarded and cumulative counters are untouched.
- All counters saturate at all-ones; no wrap-around.
- `hist_out` = 00 when `hist_idx` ≥ `hist_len`.

## Timing
- Reset values: all counters 0, `hist_len` 0, history 00, `winner` 00, `match_done` 0, `busy` 0, previous-`partita` register 00.
- Input sampled at edge k → registered outputs reflect it after edge k (latency 1).
- `match_done` is high for exactly the cycle after the sampling edge, coincident with the `winner` update.
- `hist_out` is combinational from `hist_idx` and the history registers; every other output is registered.
- `reset` during any state returns to IDLE on that edge regardless of other inputs.

## Structure
- Shared package `morra_pkg` holds:
  - `result_t` encoding: RES_NONE=00, RES_P1=01, RES_P2=10, RES_DRAW=11. The match engine should also adopt it.
  - `sb_state_t` enum: IDLE, PLAY, DONE.
- Sub-module `sat_counter` (parameter W; ports `inc`, `clr`, `q`) provides the saturating counters. It is instantiated seven times: three per-match tallies, `rounds_total`, and three cumulative tallies.
- The history shift register and the FSM stay in the top module.

## Test plan
- Rounds 01, 10, 11, 01 with `partita`=00 → `p1_rounds`=2, `p2_rounds`=1, `draws`=1, `rounds_total`=4. Then `hist_idx` 0..3 reads 01, 11, 10, 01; `hist_idx`=4 reads 00.
- `partita` 00→01 and held for 5 cycles → `match_done` is one pulse, `winner`=01, `p1_matches`=1 (not 5), `busy`=0. `manche`=10 while in DONE leaves `p2_rounds` unchanged.
- Same-cycle `manche`=01 and `partita` 00→10 → `p1_rounds` increments, `winner`=10, `p2_matches`=1.
- `new_match` coincident with `manche`=10 and a `partita` edge → per-match state all 0, `winner`=00, state IDLE, cumulative counters unchanged.
- 10 rounds with HIST_DEPTH=8 → `hist_len`=8 and `hist_idx`=7 returns the 3rd round. Forcing 31 or more P1 rounds with CNT_W=5 → `p1_rounds` stays at 31.
- `reset` asserted in DONE with `partita` still 11 → all outputs at reset values next cycle. After `reset` deasserts with `partita` still 11, the next clock sees the 00→11 edge, so DONE is re-entered and `draw_matches`=1.
